serial_chunk_adder: RTL
=======================

Name: serial_chunk_adder

Overview:
- Parametrised multi-cycle adder that adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock.
- Successor to the fixed 4-bit ripple adder: generic width and chunk size, registered carry between chunks, valid/ready handshakes on input and output, and a signed-overflow flag.
- Intended as an area-lean arithmetic unit for datapaths where latency is traded for gate count.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NUM_CHUNKS, WIDTH/CHUNK, derived local constant; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/carry_in valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carry_in  input  1  initial carry
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered sum
- carry_out  output  1  carry out of MSB
- overflow  output  1  two's-complement overflow

Behaviour:
- Reset (async, rst_n low): state=IDLE; in_ready=1; out_valid=0; sum=0; carry_out=0; overflow=0; chunk index=0; operand registers=0. Reset asserted mid-operation aborts the operation immediately. No partial result is ever presented.
- States: IDLE, ADD, DONE. State is binary encoded, 2 bits.
- IDLE:
  - in_ready=1.
  - On edge with in_valid=1: latch a, b, carry_in into internal registers; idx=0; go to ADD.
- ADD:
  - in_ready=0; out_valid=0.
  - Each edge: chunk idx of a_reg/b_reg is added with carry register c via the sub-module.
  - The result is written into sum bits [idx*CHUNK +: CHUNK]; c takes the chunk carry; idx increments.
  - On the edge processing idx=NUM_CHUNKS-1:
    - carry_out takes the final carry.
    - overflow = (a_reg[MSB]==b_reg[MSB]) && (new sum[MSB]!=a_reg[MSB]).
    - Go to DONE.
- DONE:
  - out_valid=1; in_ready=0.
  - sum, carry_out and overflow are held stable while out_ready=0.
  - On edge with out_ready=1: go to IDLE. out_valid drops; sum, carry_out and overflow retain their values until the next operation overwrites them.
- Latency: accept edge T → out_valid high after edge T+NUM_CHUNKS. Throughput is one operation per NUM_CHUNKS+2 cycles minimum: no accept in the same cycle as the result handoff.
- in_valid while in_ready=0 is ignored. The producer must hold operands until the handshake completes. Operands are sampled only on the accept edge; later changes on a/b do not affect an operation in flight.
- Widths:
  - The sum is modulo 2^WIDTH.
  - carry_out is the exact (WIDTH+1)-th bit.
  - {carry_out, sum} == a + b + carry_in for every input combination.
- CHUNK==WIDTH degenerates to one ADD cycle. The same FSM applies; no special-case path.
- Sum bits not yet written during ADD are don't-care internally and are never visible, because out_valid=0.
- idx width is clog2(NUM_CHUNKS), minimum 1. idx never wraps past NUM_CHUNKS-1.

Decomposition:
- Shared package (arith_pkg): state encoding constants ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2, and a clog2 helper function.
- Sub-module ripple_adder_n_bit:
  - Combinational, parameter N (=CHUNK).
  - Ports a[N], b[N], carry_in, sum[N], carry_out.
  - Built as a generate-loop chain of the existing dataflow full adder.
  - Exactly one instance sits inside serial_chunk_adder; operand chunk select is done in the parent.

Test Plan:
- WIDTH=16, CHUNK=4: a=0x00FF, b=0x0001, cin=0 → out_valid exactly 4 cycles after accept; sum=0x0100, carry_out=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, carry_out=1, overflow=0. Then a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, carry_out=0, overflow=1 (carry_in drives overflow).
- a=0x8000, b=0x8000, cin=0 with out_ready held 0 for 5 cycles → sum=0x0000, carry_out=1, overflow=1 stable throughout. in_ready=0 and in_valid pulses ignored until handshake; IDLE on the next edge after out_ready=1.
- rst_n pulsed low during the 2nd ADD cycle → out_valid=0, in_ready=1, sum=0 immediately. A following op a=0x1234, b=0x1111 → sum=0x2345 with no contamination.
- CHUNK=1 and CHUNK=16 builds: random 1000-op run with a random out_ready stall pattern → {carry_out, sum} matches the a+b+cin reference model. Latency is 16 and 1 respectively.
- Back-to-back in_valid held high → accepts spaced exactly NUM_CHUNKS+2 cycles apart. No result is dropped or duplicated (scoreboard count equals accept count).

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg: FSM state encoding and width helper shared by the serial adder
package arith_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: dataflow one-bit full adder
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

// File: rtl/ripple_adder_n_bit.sv
// ripple_adder_n_bit: combinational N-bit ripple-carry chain of full adders
module ripple_adder_n_bit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);
  logic [N:0] c;
  assign c[0] = carry_in;
  assign carry_out = c[N];
  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a(a[i]),
      .b(b[i]),
      .carry_in(c[i]),
      .sum(sum[i]),
      .carry_out(c[i+1])
    );
  end
endmodule

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: multi-cycle WIDTH-bit adder processing CHUNK bits per clock with valid/ready handshakes
module serial_chunk_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IW = clog2(NUM_CHUNKS) > 0 ? clog2(NUM_CHUNKS) : 1;
  state_t state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic c, c_chunk, last;
  assign a_chunk = a_reg[int'(idx) * CHUNK +: CHUNK];
  assign b_chunk = b_reg[int'(idx) * CHUNK +: CHUNK];
  assign last = idx == IW'(NUM_CHUNKS - 1);
  assign in_ready = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  ripple_adder_n_bit #(.N(CHUNK)) u_add (
    .a(a_chunk),
    .b(b_chunk),
    .carry_in(c),
    .sum(s_chunk),
    .carry_out(c_chunk)
  );
  always_comb begin
    state_next = state == ST_IDLE ? (in_valid ? ST_ADD : ST_IDLE) :
                 state == ST_ADD  ? (last ? ST_DONE : ST_ADD) :
                 state == ST_DONE ? (out_ready ? ST_IDLE : ST_DONE) : ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      c <= 1'b0;
      idx <= '0;
      sum <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && in_valid) begin
        a_reg <= a;
        b_reg <= b;
        c <= carry_in;
        idx <= '0;
      end
      if (state == ST_ADD) begin
        sum[int'(idx) * CHUNK +: CHUNK] <= s_chunk;
        c <= c_chunk;
        idx <= last ? '0 : idx + 1'b1;
        // the top chunk's MSB is the new sum MSB, so overflow is resolved on the last edge
        if (last) begin
          carry_out <= c_chunk;
          overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (s_chunk[CHUNK-1] != a_reg[WIDTH-1]);
        end
      end
    end
  end
endmodule
